// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to instruction memory, verifies an XOR checksum, then releases the core.
module imem_loader #(
    parameter int unsigned datasize  = 32,
    parameter int unsigned addrwidth = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    input  logic                 start,
    output logic                 mem_we,
    output logic [addrwidth-1:0] mem_addr,
    output logic [datasize-1:0]  mem_wdata,
    output logic                 core_run,
    output logic                 load_done,
    output logic                 load_error
);

    localparam int unsigned IDXW  = addrwidth + 1;
    localparam int unsigned CMPW  = ((IDXW > 16) ? IDXW : 16) + 1;
    localparam int unsigned DEPTH = 1 << addrwidth;

    typedef enum logic [2:0] {
        HDR0, HDR1, DATA, CSUM, DONE, ERR
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            byte_q, byte_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [datasize-1:0]   csum_q, csum_d;
    logic [23:0]           asm_q, asm_d;
    logic                  mem_we_q, mem_we_d;
    logic [addrwidth-1:0]  mem_addr_q, mem_addr_d;
    logic [datasize-1:0]   mem_wdata_q, mem_wdata_d;
    logic                  core_run_q, core_run_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  xfer_c;
    logic [15:0]           count_c;
    logic [datasize-1:0]   word_c;
    logic [23:0]           asm_ins_c;

    // Ready is a pure state decode so it reads 1 while held in reset.
    assign rx_ready   = (state_q != DONE) && (state_q != ERR);
    assign xfer_c     = rx_valid && rx_ready;
    assign count_c    = {rx_data, cnt_q[7:0]};
    assign word_c     = datasize'({rx_data, asm_q});

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_run   = core_run_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    // Byte lane insertion for bytes 0..2 of the word being assembled.
    always_comb begin
        asm_ins_c = asm_q;
        case (byte_q)
            2'd0:    asm_ins_c[7:0]   = rx_data;
            2'd1:    asm_ins_c[15:8]  = rx_data;
            default: asm_ins_c[23:16] = rx_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_d       = byte_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        asm_d        = asm_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_run_d   = core_run_q;
        load_done_d  = load_done_q;
        load_error_d = load_error_q;

        case (state_q)
            HDR0: begin
                if (xfer_c) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = HDR1;
                end
            end
            HDR1: begin
                if (xfer_c) begin
                    cnt_d[15:8] = rx_data;
                    if (32'(count_c) > DEPTH) begin
                        state_d      = ERR;
                        load_error_d = 1'b1;
                    end else if (count_c == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer_c) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q[addrwidth-1:0];
                        mem_wdata_d = word_c;
                        csum_d      = csum_q ^ word_c;
                        idx_d       = idx_q + IDXW'(1);
                        if (CMPW'(idx_q) + CMPW'(1) == CMPW'(cnt_q)) begin
                            state_d = CSUM;
                        end
                    end else begin
                        asm_d = asm_ins_c;
                    end
                end
            end
            CSUM: begin
                if (xfer_c) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        if (word_c == csum_q) begin
                            state_d     = DONE;
                            core_run_d  = 1'b1;
                            load_done_d = 1'b1;
                        end else begin
                            state_d      = ERR;
                            load_error_d = 1'b1;
                        end
                    end else begin
                        asm_d = asm_ins_c;
                    end
                end
            end
            DONE, ERR: begin
                if (start) begin
                    state_d      = HDR0;
                    core_run_d   = 1'b0;
                    load_done_d  = 1'b0;
                    load_error_d = 1'b0;
                    csum_d       = '0;
                    idx_d        = '0;
                    byte_d       = '0;
                end
            end
            default: state_d = HDR0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HDR0;
            cnt_q        <= '0;
            byte_q       <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            asm_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_run_q   <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_q       <= byte_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            asm_q        <= asm_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_run_q   <= core_run_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-stream loads plus hand-written
// reset-abort and full-depth (256-word) sequences.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_run;
    logic        load_done;
    logic        load_error;

    imem_loader #(.datasize(32), .addrwidth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_run   (core_run),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial forever #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write monitor: records every mem_we cycle and flags any pulse wider than 1 cycle.
    logic [7:0]  wr_addr [300];
    logic [31:0] wr_data [300];
    int          wr_at   [300];
    int          nw      = 0;
    int          dbl     = 0;
    int          nacc    = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (nw < 300) begin
                wr_addr[nw] = mem_addr;
                wr_data[nw] = mem_wdata;
                wr_at[nw]   = nacc;
            end
            nw++;
            if (prev_we === 1'b1) dbl++;
        end
        prev_we = mem_we;
    end

    typedef struct {
        logic [127:0] stream;   // first byte is the most significant of nbytes
        int           nbytes;
        bit           gaps;
        bit           poke;     // pulse start on byte 4 (must be ignored)
        int           exp_nw;
        logic [7:0]   a0;
        logic [31:0]  d0;
        logic [7:0]   a1;
        logic [31:0]  d1;
        bit           exp_done;
        bit           exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit st);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                start    = 1'b0;
            end
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        start    = st;
        if (rx_ready !== 1'b1) begin
            check("rx_ready_while_loading", 32'(rx_ready), 32'd1);
        end
        @(posedge clk);
        nacc++;
    endtask

    task automatic finish_stream();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        #1;
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        v    = vecs[k];
        nw   = 0;
        dbl  = 0;
        nacc = 0;
        for (int i = 0; i < v.nbytes; i++) begin
            send_byte(v.stream[8*(v.nbytes-1-i) +: 8], v.gaps, v.poke && (i == 4));
            if (i == v.nbytes - 2) begin
                #1;
                check($sformatf("v%0d_flags_before_last", k),
                      {29'd0, core_run, load_done, load_error}, 32'd0);
            end
        end
        finish_stream();
        check($sformatf("v%0d_nwrites", k), 32'(nw), 32'(v.exp_nw));
        if (v.exp_nw >= 1) begin
            check($sformatf("v%0d_addr0", k), 32'(wr_addr[0]), 32'(v.a0));
            check($sformatf("v%0d_data0", k), wr_data[0], v.d0);
            check($sformatf("v%0d_at0", k), 32'(wr_at[0]), 32'd6);
        end
        if (v.exp_nw >= 2) begin
            check($sformatf("v%0d_addr1", k), 32'(wr_addr[1]), 32'(v.a1));
            check($sformatf("v%0d_data1", k), wr_data[1], v.d1);
            check($sformatf("v%0d_at1", k), 32'(wr_at[1]), 32'd10);
        end
        check($sformatf("v%0d_core_run", k), 32'(core_run), 32'(v.exp_done));
        check($sformatf("v%0d_load_done", k), 32'(load_done), 32'(v.exp_done));
        check($sformatf("v%0d_load_error", k), 32'(load_error), 32'(v.exp_err));
        check($sformatf("v%0d_rx_ready_end", k), 32'(rx_ready), 32'd0);
        check($sformatf("v%0d_we_width", k), 32'(dbl), 32'd0);
    endtask

    task automatic rearm(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check({nm, "_flags"}, {29'd0, core_run, load_done, load_error}, 32'd0);
        check({nm, "_rx_ready"}, 32'(rx_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] cs;
        logic [79:0] s1;

        vecs[0] = '{128'h0200_13000120_FFFF0220_ECFF0300, 14, 1'b0, 1'b0, 2,
                    8'd0, 32'h20010013, 8'd1, 32'h2002FFFF, 1'b1, 1'b0};
        vecs[1] = '{128'h0200_13000120_FFFF0220_ECFF0301, 14, 1'b0, 1'b0, 2,
                    8'd0, 32'h20010013, 8'd1, 32'h2002FFFF, 1'b0, 1'b1};
        vecs[2] = '{128'h0000_00000000, 6, 1'b0, 1'b0, 0,
                    8'd0, 32'h0, 8'd0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{128'h0101, 2, 1'b0, 1'b0, 0,
                    8'd0, 32'h0, 8'd0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{128'h0200_13000120_FFFF0220_ECFF0300, 14, 1'b1, 1'b0, 2,
                    8'd0, 32'h20010013, 8'd1, 32'h2002FFFF, 1'b1, 1'b0};
        vecs[5] = '{128'h0100_78563412_78563412, 10, 1'b0, 1'b1, 1,
                    8'd0, 32'h12345678, 8'd0, 32'h0, 1'b1, 1'b0};

        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_flags", {29'd0, core_run, load_done, load_error}, 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            run_vec(k);
            rearm($sformatf("rearm%0d", k));
        end

        // Reset mid-load after 5 data bytes, then a fresh load from address 0.
        nw   = 0;
        nacc = 0;
        s1   = 80'h0200_11223344_55_000000;
        for (int i = 0; i < 7; i++) send_byte(s1[8*(9-i) +: 8], 1'b0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        #1;
        check("abort_pre_writes", 32'(nw), 32'd1);
        check("abort_pre_data", wr_data[0], 32'h44332211);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_flags", {29'd0, core_run, load_done, load_error}, 32'd0);
        check("abort_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        nw    = 0;
        nacc  = 0;
        s1    = 80'h0100_EFBEADDE_EFBEADDE;
        for (int i = 0; i < 10; i++) send_byte(s1[8*(9-i) +: 8], 1'b0, 1'b0);
        finish_stream();
        check("reload_nwrites", 32'(nw), 32'd1);
        check("reload_addr", 32'(wr_addr[0]), 32'd0);
        check("reload_data", wr_data[0], 32'hDEADBEEF);
        check("reload_done", {30'd0, core_run, load_done}, 32'd3);
        rearm("rearm_reload");

        // Full-depth load: N = 256 is legal and fills addresses 0..255.
        nw   = 0;
        dbl  = 0;
        nacc = 0;
        cs   = 32'd0;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w  = (32'(i) * 32'h01010101) ^ 32'hC0DE0000;
            cs = cs ^ w;
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0, 1'b0);
        end
        for (int b = 0; b < 4; b++) send_byte(cs[8*b +: 8], 1'b0, 1'b0);
        finish_stream();
        check("full_nwrites", 32'(nw), 32'd256);
        check("full_addr0", 32'(wr_addr[0]), 32'd0);
        check("full_addr128", 32'(wr_addr[128]), 32'd128);
        check("full_data128", wr_data[128], (32'd128 * 32'h01010101) ^ 32'hC0DE0000);
        check("full_addr255", 32'(wr_addr[255]), 32'd255);
        check("full_data255", wr_data[255], (32'd255 * 32'h01010101) ^ 32'hC0DE0000);
        check("full_at255", 32'(wr_at[255]), 32'd1026);
        check("full_done", {29'd0, core_run, load_done, load_error}, 32'd6);
        check("full_we_width", 32'(dbl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
